imem_loader: RTL and testbench

- Byte-stream program loader for the single-cycle MIPS core; the write-side counterpart to the bench's hierarchical read of instruction memory.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word into the instruction-memory write port.
- Holds the core's `enable` low while loading and releases it once the image is complete.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the single-cycle MIPS core.
// Receives a framed image (16-bit LE word count, then LE 32-bit words) over a
// valid/ready byte interface, writes each word to the instruction memory and
// holds the core's enable low until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the core is released.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_enable,
    output logic              busy,
    output logic              err,
    output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    // Largest image that fits in the memory, widened so the compare never overflows.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t      state;
    logic [15:0] n_words;   // word count from the header
    logic [1:0]  bcnt;      // byte index within the header or the current word
    logic [23:0] word_lo;   // first three bytes of the word being assembled
    logic [15:0] n_full;    // header value once its second byte arrives
    logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;      // running XOR of every frame byte so far
    logic [7:0]  csum_next;
`endif

    // Handshake and header decode shared by several states.
    always_comb begin
        accept = rx_valid && rx_ready;
        n_full = {rx_data, n_words[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next = csum ^ rx_data;
`endif
    end

    // Loader FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_enable   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
            bcnt         <= '0;
            word_lo      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        state        <= S_HDR;
                        rx_ready     <= 1'b1;
                        busy         <= 1'b1;
                        cpu_enable   <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        bcnt         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum_next;
`endif
                        if (bcnt == 2'd0) begin
                            n_words[7:0] <= rx_data;
                            bcnt         <= 2'd1;
                        end else begin
                            n_words <= n_full;
                            bcnt    <= 2'd0;
                            if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state      <= S_CHK;
                                rx_ready   <= 1'b1;
`else
                                state      <= S_DONE;
                                rx_ready   <= 1'b0;
                                busy       <= 1'b0;
                                cpu_enable <= 1'b1;
`endif
                            end else if ({16'd0, n_full} > CAPACITY) begin
                                state    <= S_ERR;
                                rx_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum_next;
`endif
                        if (bcnt == 2'd3) begin
                            // Present the write during the single WRITE cycle.
                            state     <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(BASE_ADDR + 32'(words_loaded));
                            mem_wdata <= {rx_data, word_lo};
                            bcnt      <= 2'd0;
                        end else begin
                            word_lo <= {rx_data, word_lo[23:8]};
                            bcnt    <= bcnt + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    if (words_loaded + 16'd1 == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= S_CHK;
                        rx_ready   <= 1'b1;
`else
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        cpu_enable <= 1'b1;
`endif
                    end else begin
                        state    <= S_LOAD;
                        rx_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= S_DONE;
                            cpu_enable <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads with continuous and gapped
// valid, empty image, oversize header, mid-load reset and (when
// IMEM_LOADER_CHECKSUM_EN is defined) checksum match and mismatch.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_enable;
    logic              busy;
    logic              err;
    logic [15:0]       words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int en_rise_cyc = 0;
    logic prev_en = 1'b0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_enable(cpu_enable), .busy(busy), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and write-port monitor, sampled mid-cycle.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            last_we_cyc <= cyc;
            check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
        end
        if (cpu_enable && !prev_en) en_rise_cyc <= cyc;
        prev_en <= cpu_enable;
    end

    // All tasks start and end just after a falling edge.
    task automatic load_pulse();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept_wait", {31'd0, (t >= 40)}, 32'd0);
        @(negedge clk);
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gap);
        foreach (fr[i]) send(fr[i], gap);
        rx_valid = 1'b0;
    endtask

    task automatic wait_enable();
        int t = 0;
        while (!cpu_enable && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("enable_wait", {31'd0, cpu_enable}, 32'd1);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_count"}, wa_q.size(), 32'd2);
        check({tag, "_addr0"}, {24'd0, wa_q[0]}, 32'd0);
        check({tag, "_data0"}, wd_q[0], 32'h2000_0013);
        check({tag, "_addr1"}, {24'd0, wa_q[1]}, 32'd1);
        check({tag, "_data1"}, wd_q[1], 32'h0800_0008);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] frame1[$];
        logic [7:0] empty_hdr[$];
        logic [7:0] partial[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame1    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h08, 8'h31};
        empty_hdr = '{8'h00, 8'h00, 8'h00};
`else
        frame1    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h08};
        empty_hdr = '{8'h00, 8'h00};
`endif
        partial = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08};

        // Reset state
        #12;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word frame, valid held high
        clear_log();
        load_pulse();
        check("hdr_busy", {31'd0, busy}, 32'd1);
        check("hdr_ready", {31'd0, rx_ready}, 32'd1);
        send_frame(frame1, 1'b0);
        wait_enable();
        repeat (2) @(negedge clk);
        check_two_words("held");
        check("held_busy", {31'd0, busy}, 32'd0);
        check("held_err", {31'd0, err}, 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("held_enable_latency", en_rise_cyc - last_we_cyc, 32'd1);
`endif

        // Same frame with valid toggling; load_req from DONE drops enable
        clear_log();
        load_pulse();
        check("restart_enable_low", {31'd0, cpu_enable}, 32'd0);
        check("restart_ready", {31'd0, rx_ready}, 32'd1);
        send_frame(frame1, 1'b1);
        wait_enable();
        repeat (2) @(negedge clk);
        check_two_words("gapped");

        // Empty image
        clear_log();
        load_pulse();
        send_frame(empty_hdr, 1'b0);
        wait_enable();
        repeat (2) @(negedge clk);
        check("empty_no_write", wa_q.size(), 32'd0);
        check("empty_words", {16'd0, words_loaded}, 32'd0);

        // Oversize header 0x0101 > 256 words
        load_pulse();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        rx_valid = 1'b0;
        check("over_err", {31'd0, err}, 32'd1);
        check("over_enable", {31'd0, cpu_enable}, 32'd0);
        check("over_ready", {31'd0, rx_ready}, 32'd0);
        check("over_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("over_err_sticky", {31'd0, err}, 32'd1);
        load_pulse();
        check("retry_err_clear", {31'd0, err}, 32'd0);
        check("retry_busy", {31'd0, busy}, 32'd1);
        check("retry_ready", {31'd0, rx_ready}, 32'd1);
        send_frame(empty_hdr, 1'b0);
        wait_enable();

        // Asynchronous reset after five payload bytes
        clear_log();
        load_pulse();
        send_frame(partial, 1'b0);
        check("partial_one_write", wa_q.size(), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("arst_words", {16'd0, words_loaded}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, rx_ready}, 32'd0);
        check("arst_enable", {31'd0, cpu_enable}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        load_pulse();
        send_frame(frame1, 1'b0);
        wait_enable();
        repeat (2) @(negedge clk);
        check_two_words("after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match (0x45) and mismatch (0x00)
        clear_log();
        load_pulse();
        send_frame('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 1'b0);
        wait_enable();
        check("csum_ok_err", {31'd0, err}, 32'd0);
        check("csum_ok_data", wd_q[0], 32'h4433_2211);
        clear_log();
        load_pulse();
        send_frame('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 1'b0);
        repeat (3) @(negedge clk);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_enable", {31'd0, cpu_enable}, 32'd0);
        check("csum_bad_written", wa_q.size(), 32'd1);
        check("csum_bad_data", wd_q[0], 32'h4433_2211);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
